// File: rtl/vec_ex_wb_buffer.sv
// Writeback buffer between the vector execution unit and the vector register file write port.
// Latency: one cycle from push to wb_valid. There is no same-cycle bypass.
// Backpressure: ex_ready drops when the buffer is full or during reset/flush, and never depends on wb_ready.
//
// Ports:
//   clk, reset (sync, active-high), flush (sync clear of all entries)
//   ex_*       : result handshake from the execution unit (data, vd, sew, vl, vm, v0 mask)
//   wb_*       : write request to the register file, always showing the head entry
//   pending_vd : one bit per vector register that has an entry still queued
//   count      : number of occupied entries
module vec_ex_wb_buffer #(
    parameter int VLEN  = 128,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         ex_valid,
    output logic                         ex_ready,
    input  logic [VLEN-1:0]              ex_result,
    input  logic [4:0]                   ex_vd,
    input  logic [1:0]                   ex_sew,
    input  logic [$clog2(VLEN/8):0]      ex_vl,
    input  logic                         ex_vm,
    input  logic [VLEN/8-1:0]            ex_vmask,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [4:0]                   wb_vd,
    output logic [VLEN-1:0]              wb_data,
    output logic [VLEN/8-1:0]            wb_be,
    output logic [31:0]                  pending_vd,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int NB  = VLEN / 8;
    localparam int IW  = $clog2(NB);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [VLEN-1:0] data;
        logic [4:0]      vd;
        logic [NB-1:0]   be;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;

    logic            push;
    logic            pop;
    logic [NB-1:0]   be_new;
    logic [IW-1:0]   eidx;
    entry_t          head;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Byte b belongs to element b >> sew. That index is always below VLMAX,
    // so comparing it with the raw vl already clamps vl to VLMAX.
    always_comb begin
        be_new = '0;
        eidx   = '0;
        for (int b = 0; b < NB; b++) begin
            eidx      = IW'(b >> ex_sew);
            be_new[b] = ({1'b0, eidx} < ex_vl) && (ex_vm || ex_vmask[eidx]);
        end
    end

    assign ex_ready = (count_q < CW'(DEPTH)) && !reset && !flush;

    // A vl=0 result completes its handshake but carries no write, so it is not queued.
    assign push     = ex_valid && ex_ready && (ex_vl != '0);
    assign pop      = wb_valid && wb_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // wr_ptr == rd_ptr only when empty or full, so push and pop never
            // touch the same slot in one cycle.
            if (push) begin
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by vld_q/count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: ex_result, vd: ex_vd, be: be_new};
        end
    end

    always_comb begin
        pending_vd = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_q[k]) begin
                pending_vd[mem[k].vd] = 1'b1;
            end
        end
    end

    assign head     = mem[rd_ptr];
    assign wb_valid = (count_q != '0);
    assign wb_vd    = wb_valid ? head.vd   : '0;
    assign wb_data  = wb_valid ? head.data : '0;
    assign wb_be    = wb_valid ? head.be   : '0;
    assign count    = count_q;

endmodule

// File: doc/vec_ex_wb_buffer.md
Name: vec_ex_wb_buffer

Overview:
- Writeback stage directly downstream of the vector execution unit.
- Captures each VLEN-wide result with its destination register, SEW, vl and mask.
- Converts vl, SEW and mask into per-byte write enables (tail and masked-off bytes left undisturbed), and queues results in a small FIFO in front of the vector register file write port.
- Exposes a pending-destination bitmap so the issue logic can stall on RAW hazards.

Parameters:
- VLEN, 128, vector register width in bits; must be a multiple of 64.
- DEPTH, 2, number of FIFO entries; must be ≥1.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all entries (trap/kill).
- ex_valid  input  1  execution result valid.
- ex_ready  output  1  buffer can accept.
- ex_result  input  VLEN  result data from the execution unit.
- ex_vd  input  5  destination vector register.
- ex_sew  input  2  element width: 00=8, 01=16, 10=32, 11=64.
- ex_vl  input  $clog2(VLEN/8)+1  active element count.
- ex_vm  input  1  1 = unmasked, 0 = masked by ex_vmask.
- ex_vmask  input  VLEN/8  v0 mask bits; bit i belongs to element i.
- wb_valid  output  1  write request to the register file.
- wb_ready  input  1  register file accepts the write.
- wb_vd  output  5  destination register.
- wb_data  output  VLEN  write data.
- wb_be  output  VLEN/8  byte enables; bit b covers wb_data[8b+7:8b].
- pending_vd  output  32  bit r = 1 iff a valid entry targets vr.
- count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (clk edge with reset=1):
  - count=0, wb_valid=0, pending_vd=0, read and write pointers = 0.
  - wb_vd, wb_data and wb_be are driven to 0 while empty.
- ex_ready:
  - ex_ready = (count < DEPTH) && !reset && !flush.
  - It depends only on registered state, never on wb_ready. There is no pass-through when full.
- Push: ex_valid && ex_ready at a clock edge.
- Pop: wb_valid && wb_ready at a clock edge.
- Byte-enable generation at push (combinational from ex_* inputs, stored in the entry):
  - Element size E = 1 << ex_sew bytes.
  - VLMAX = VLEN/(8·E); effective vl = min(ex_vl, VLMAX).
  - Element i (i < VLMAX) is active iff i < effective vl and (ex_vm || ex_vmask[i]).
  - Bytes i·E .. i·E+E−1 of wb_be take the active value of element i.
- vl = 0: the push handshake completes but nothing is enqueued. count and pending_vd are unchanged.
- Latency: a push into an empty buffer gives wb_valid=1 on the following cycle. There is no same-cycle bypass.
- wb_* outputs always show the head entry. They stay stable while wb_valid && !wb_ready.
- Push and pop in the same cycle with 0 < count < DEPTH: count is unchanged and both pointers advance.
- At count == DEPTH only a pop is possible, since ex_ready=0.
- Pointers wrap modulo DEPTH.
- pending_vd is the OR over valid entries of the one-hot of vd, recomputed from registered state.
  - Two entries with the same vd keep the bit set until both have popped.
- flush (priority below reset, above push/pop):
  - Next state is empty: count=0, pointers=0, pending_vd=0, wb_valid=0.
  - A concurrent push is dropped; ex_ready is 0 that cycle.
  - A concurrent pop is ignored; the register file must not commit a write with wb_valid sampled in a flush cycle.
- Reset asserted mid-operation discards all entries, exactly as flush does.
- ex_sew and ex_vl values are not checked further. Out-of-range vl is clamped as above.

Test Plan (VLEN=128, DEPTH=2):
- SEW32 (ex_sew=10), vl=3, vm=1, vd=5, wb_ready=1 → next cycle wb_valid=1, wb_vd=5, wb_be=16'h0FFF, pending_vd=32'h20 for one cycle, then 0.
- SEW16, vl=8, vm=0, vmask[7:0]=8'b10100101 → wb_be=16'hCC33.
- SEW8, vl=20 (>VLMAX=16), vm=1 → wb_be=16'hFFFF.
- SEW64, vl=0 → ex_ready=1 and the handshake completes; wb_valid stays 0; count stays 0.
- wb_ready=0, push vd=3 then vd=3:
  - count=2 and ex_ready=0; a third ex_valid is held off.
  - pending_vd[3]=1 until the second pop.
  - Raising wb_ready gives two writes in order on consecutive cycles, with wb_data stable while stalled.
- count=1 with simultaneous push and pop → count stays 1 and data comes out in order.
- flush asserted with count=2 and ex_valid=1 → next cycle count=0, wb_valid=0, pending_vd=0, and the pushed result is lost.
